// File: rtl/stream_width_downsizer.sv
// stream_width_downsizer: splits each IN_WIDTH word into RATIO OUT_WIDTH beats on a valid/ready stream
module stream_width_downsizer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CW    = RATIO > 1 ? $clog2(RATIO) : 1;
    generate
        if (OUT_WIDTH < 1 || IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_width
            $error("IN_WIDTH must be an integer multiple of OUT_WIDTH");
        end
    endgenerate
    logic [IN_WIDTH-1:0] word_reg;
    logic                last_reg;
    logic                full;
    logic [CW-1:0]       beat_cnt;
    logic                accept;
    logic                consume;
    logic                final_beat;
    int                  sel;
    logic [IN_WIDTH-1:0] shifted;
    assign final_beat = beat_cnt == CW'(RATIO - 1);
    assign out_valid  = full;
    assign in_ready   = !full || (out_ready && final_beat);
    assign accept     = in_valid && in_ready;
    assign consume    = out_valid && out_ready;
    assign out_last   = full && last_reg && final_beat;
    assign sel        = MSB_FIRST ? RATIO - 1 - int'(beat_cnt) : int'(beat_cnt);
    assign shifted    = word_reg >> (sel * OUT_WIDTH);
    assign out_data   = shifted[OUT_WIDTH-1:0];
    // Advance through the held word's beats; reload on the final beat so words flow without a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg <= '0;
            last_reg <= 1'b0;
            full     <= 1'b0;
            beat_cnt <= '0;
        end else if (consume) begin
            if (final_beat) begin
                beat_cnt <= '0;
                full     <= accept;
                if (accept) begin
                    word_reg <= in_data;
                    last_reg <= in_last;
                end
            end else begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end else if (accept) begin
            word_reg <= in_data;
            last_reg <= in_last;
            full     <= 1'b1;
            beat_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_stream_width_downsizer.sv
// tb_stream_width_downsizer: scoreboard bench for LSB-first, MSB-first and 1:1 configurations
module tb_stream_width_downsizer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid = 0, a_in_last = 0, a_in_ready, a_out_valid, a_out_last, a_out_ready = 1;
    logic [31:0] a_in_data = 0;
    logic [7:0]  a_out_data;
    logic        b_in_valid = 0, b_in_last = 0, b_in_ready, b_out_valid, b_out_last, b_out_ready = 1;
    logic [31:0] b_in_data = 0;
    logic [7:0]  b_out_data;
    logic        c_in_valid = 0, c_in_last = 0, c_in_ready, c_out_valid, c_out_last, c_out_ready = 1;
    logic [31:0] c_in_data = 0;
    logic [31:0] c_out_data;

    stream_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data), .in_last(a_in_last),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
        .out_ready(a_out_ready));
    stream_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
        .out_ready(b_out_ready));
    stream_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(32), .MSB_FIRST(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_data(c_in_data), .in_last(c_in_last),
        .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data), .out_last(c_out_last),
        .out_ready(c_out_ready));

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_a = 0;
    logic [32:0] q_a[$], q_b[$], q_c[$];
    int cons_a[$], cons_c[$];
    logic        a_stall = 0;
    logic [8:0]  a_prev = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] d, input logic l);
        bit done = 0;
        a_in_valid = 1;
        a_in_data  = d;
        a_in_last  = l;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = a_in_ready;
            step();
        end
        check("a_send_accepted", 32'(done), 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the LSB-first instance: scoreboard, stall stability and accept count
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            q_a.delete();
            a_stall = 0;
        end else begin
            if (a_out_valid && a_out_ready) begin
                check("a_beat_expected", 32'(q_a.size() != 0), 1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    check("a_data", 32'(a_out_data), 32'(e[7:0]));
                    check("a_last", 32'(a_out_last), 32'(e[32]));
                end
                cons_a.push_back(cyc);
            end
            if (a_stall) begin
                check("a_stall_valid", 32'(a_out_valid), 1);
                check("a_stall_stable", 32'({a_out_last, a_out_data}), 32'(a_prev));
            end
            a_stall = a_out_valid && !a_out_ready;
            a_prev  = {a_out_last, a_out_data};
            if (a_in_valid && a_in_ready) begin
                acc_a++;
                for (int i = 0; i < 4; i++)
                    q_a.push_back({a_in_last && i == 3, 24'h0, a_in_data[i*8 +: 8]});
            end
        end
    end

    // Monitor for the MSB-first instance
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) q_b.delete();
        else begin
            if (b_out_valid && b_out_ready) begin
                check("b_beat_expected", 32'(q_b.size() != 0), 1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    check("b_data", 32'(b_out_data), 32'(e[7:0]));
                    check("b_last", 32'(b_out_last), 32'(e[32]));
                end
            end
            if (b_in_valid && b_in_ready)
                for (int i = 0; i < 4; i++)
                    q_b.push_back({b_in_last && i == 3, 24'h0, b_in_data[(3-i)*8 +: 8]});
        end
    end

    // Monitor for the 1:1 instance
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) q_c.delete();
        else begin
            if (c_out_valid && c_out_ready) begin
                check("c_beat_expected", 32'(q_c.size() != 0), 1);
                if (q_c.size() != 0) begin
                    e = q_c.pop_front();
                    check("c_data", c_out_data, e[31:0]);
                    check("c_last", 32'(c_out_last), 32'(e[32]));
                end
                cons_c.push_back(cyc);
            end
            if (c_in_valid && c_in_ready) q_c.push_back({c_in_last, c_in_data});
        end
    end

    initial begin
        logic [6:0] pat;
        int acc0;
        pat = 7'b1011001;
        repeat (2) step();
        check("rst_out_valid", 32'(a_out_valid), 0);
        check("rst_out_last", 32'(a_out_last), 0);
        check("rst_out_data", 32'(a_out_data), 0);
        check("rst_in_ready", 32'(a_in_ready), 1);
        rst_n = 1;
        step();
        check("post_rst_out_valid", 32'(a_out_valid), 0);
        check("post_rst_in_ready", 32'(a_in_ready), 1);
        // single word, LSB first
        send_a(32'hDDCCBBAA, 0);
        a_in_valid = 0;
        check("a1_first_beat", 32'(a_out_data), 32'hAA);
        repeat (3) step();
        check("a1_beat4_data", 32'(a_out_data), 32'hDD);
        check("a1_beat4_in_ready", 32'(a_in_ready), 1);
        step();
        check("a1_idle_valid", 32'(a_out_valid), 0);
        // back-to-back words, continuous stream
        cons_a.delete();
        acc0 = acc_a;
        send_a(32'h03020100, 0);
        send_a(32'h07060504, 1);
        a_in_valid = 0;
        repeat (8) step();
        check("a2_beats", 32'(cons_a.size()), 8);
        if (cons_a.size() == 8) check("a2_no_gap", 32'(cons_a[7] - cons_a[0]), 7);
        check("a2_accepts", 32'(acc_a - acc0), 2);
        check("a2_idle_valid", 32'(a_out_valid), 0);
        // backpressure pattern on the output
        send_a(32'h44332211, 0);
        a_in_valid = 0;
        for (int i = 0; i < 7; i++) begin
            a_out_ready = pat[6-i];
            @(negedge clk);
            check("a3_in_ready", 32'(a_in_ready), 32'(i == 6));
            step();
        end
        a_out_ready = 1;
        check("a3_idle_valid", 32'(a_out_valid), 0);
        // asynchronous reset in the middle of a word
        send_a(32'hA1B2C3D4, 0);
        a_in_valid = 0;
        repeat (2) step();
        check("a4_mid_valid", 32'(a_out_valid), 1);
        #2 rst_n = 0;
        #1;
        check("a4_rst_out_valid", 32'(a_out_valid), 0);
        check("a4_rst_out_last", 32'(a_out_last), 0);
        check("a4_rst_in_ready", 32'(a_in_ready), 1);
        step();
        rst_n = 1;
        step();
        send_a(32'h000000EE, 0);
        a_in_valid = 0;
        check("a4_first_after_rst", 32'(a_out_data), 32'hEE);
        repeat (5) step();
        // MSB-first instance
        b_in_valid = 1;
        b_in_data  = 32'hDDCCBBAA;
        b_in_last  = 1;
        @(negedge clk);
        check("b_in_ready", 32'(b_in_ready), 1);
        step();
        b_in_valid = 0;
        check("b_first_beat", 32'(b_out_data), 32'hDD);
        repeat (5) step();
        // 1:1 instance, full rate
        cons_c.delete();
        c_in_valid = 1;
        for (int k = 1; k <= 3; k++) begin
            c_in_data = 32'(k);
            c_in_last = k == 3;
            @(negedge clk);
            check("c_in_ready", 32'(c_in_ready), 1);
            step();
            check("c_latency_valid", 32'(c_out_valid), 1);
            check("c_latency_data", c_out_data, 32'(k));
        end
        c_in_valid = 0;
        step();
        check("c_idle_valid", 32'(c_out_valid), 0);
        check("c_beats", 32'(cons_c.size()), 3);
        if (cons_c.size() == 3) check("c_no_gap", 32'(cons_c[2] - cons_c[0]), 2);
        repeat (2) step();
        check("a_queue_drained", 32'(q_a.size()), 0);
        check("b_queue_drained", 32'(q_b.size()), 0);
        check("c_queue_drained", 32'(q_c.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
